// File: rtl/simeck_dec_ctrl.sv
// simeck_dec_ctrl
// Sequencer for one Simeck decrypter datapath. Walks a job through
// IDLE -> INIT -> LOAD -> ROUND -> SAVE -> VALID and drives the datapath
// strobes. It holds no data of its own.
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous, active-high
//   start      host job request; accepted on an edge where start & start_rdy
//   start_rdy  high only while idle and not in reset
//   abort      synchronous abort of the running job (ignored while idle)
//   word_idx   key/cipher word the host must drive during a LOAD cycle
//   dp_reset   datapath reset strobe (INIT)
//   lfsrset    round-constant LFSR preset (INIT)
//   dctr/kctr  0 = load, 1 = round, for data and key paths
//   save       one-cycle plaintext capture pulse
//   out_valid  plaintext valid, held until out_rdy
//   out_rdy    host consumes plaintext
//   busy       state is not IDLE
module simeck_dec_ctrl #(
    parameter int ROUNDS  = 32,
    parameter int LOADCYC = 4,
    parameter int IDXW    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            start_rdy,
    input  logic            abort,
    output logic [IDXW-1:0] word_idx,
    output logic            dp_reset,
    output logic            lfsrset,
    output logic            dctr,
    output logic            kctr,
    output logic            save,
    output logic            out_valid,
    input  logic            out_rdy,
    output logic            busy
);

    // One spare bit so the round counter can never wrap inside a job.
    localparam int RCW = $clog2(ROUNDS) + 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(LOADCYC - 1);
    localparam logic [RCW-1:0]  RND_LAST = RCW'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_LOAD, S_ROUND, S_SAVE, S_VALID
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [RCW-1:0]  rnd_q, rnd_d;

    logic [IDXW-1:0] word_idx_q, word_idx_d;
    logic            dp_reset_q, dp_reset_d;
    logic            lfsrset_q, lfsrset_d;
    logic            dctr_q, dctr_d;
    logic            kctr_q, kctr_d;
    logic            save_q, save_d;
    logic            out_valid_q, out_valid_d;

    // Next state and counters
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rnd_d   = rnd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    idx_d   = '0;
                    rnd_d   = '0;
                end
            end
            S_INIT:  state_d = S_LOAD;
            S_LOAD: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_ROUND;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_ROUND: begin
                if (rnd_q == RND_LAST) begin
                    state_d = S_SAVE;
                    rnd_d   = '0;
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end
            S_SAVE:  state_d = S_VALID;
            S_VALID: if (out_rdy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort only matters once a job is running; start wins in IDLE.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            rnd_d   = '0;
        end
    end

    // Strobes are decoded from the next state and registered, so they line
    // up with the state they describe and never glitch (save is a clock
    // downstream).
    always_comb begin
        word_idx_d  = (state_d == S_LOAD) ? idx_d : '0;
        dp_reset_d  = (state_d == S_INIT);
        lfsrset_d   = (state_d == S_INIT);
        dctr_d      = (state_d == S_ROUND);
        kctr_d      = (state_d == S_ROUND);
        save_d      = (state_d == S_SAVE);
        out_valid_d = (state_d == S_VALID);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rnd_q       <= '0;
            word_idx_q  <= '0;
            dp_reset_q  <= 1'b0;
            lfsrset_q   <= 1'b0;
            dctr_q      <= 1'b0;
            kctr_q      <= 1'b0;
            save_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rnd_q       <= rnd_d;
            word_idx_q  <= word_idx_d;
            dp_reset_q  <= dp_reset_d;
            lfsrset_q   <= lfsrset_d;
            dctr_q      <= dctr_d;
            kctr_q      <= kctr_d;
            save_q      <= save_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign word_idx  = word_idx_q;
    assign dp_reset  = dp_reset_q;
    assign lfsrset   = lfsrset_q;
    assign dctr      = dctr_q;
    assign kctr      = kctr_q;
    assign save      = save_q;
    assign out_valid = out_valid_q;

    // Gated by reset so the host never sees a ready it cannot use.
    assign start_rdy = (state_q == S_IDLE) && !reset;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_simeck_dec_ctrl.sv
// Bench for simeck_dec_ctrl. Two instances share stimulus: the default
// 32-round/4-load build and a 44-round/3-load build. A job-timeline model
// (cycles since acceptance) predicts every output each cycle; directed
// scenarios add literal expectations on latency and strobe counts.
module tb_simeck_dec_ctrl;

    logic clk = 1'b0;
    logic reset, start, abort, out_rdy;
    logic [1:0] start_rdy, busy, dp_reset, lfsrset, dctr, kctr, save, out_valid;
    logic [1:0] word_idx [2];

    always #5 clk = ~clk;

    simeck_dec_ctrl #(.ROUNDS(32), .LOADCYC(4), .IDXW(2)) u0 (
        .clk(clk), .reset(reset), .start(start), .start_rdy(start_rdy[0]),
        .abort(abort), .word_idx(word_idx[0]), .dp_reset(dp_reset[0]),
        .lfsrset(lfsrset[0]), .dctr(dctr[0]), .kctr(kctr[0]), .save(save[0]),
        .out_valid(out_valid[0]), .out_rdy(out_rdy), .busy(busy[0]));

    simeck_dec_ctrl #(.ROUNDS(44), .LOADCYC(3), .IDXW(2)) u1 (
        .clk(clk), .reset(reset), .start(start), .start_rdy(start_rdy[1]),
        .abort(abort), .word_idx(word_idx[1]), .dp_reset(dp_reset[1]),
        .lfsrset(lfsrset[1]), .dctr(dctr[1]), .kctr(kctr[1]), .save(save[1]),
        .out_valid(out_valid[1]), .out_rdy(out_rdy), .busy(busy[1]));

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- job-timeline model ----------------
    int Lp[2] = '{4, 3};
    int Rp[2] = '{32, 44};
    bit job[2];
    int t[2];
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (reset) job[k] = 1'b0;
            else if (!job[k]) begin
                if (start) begin job[k] = 1'b1; t[k] = 1; end
            end
            else if (abort) job[k] = 1'b0;
            else if (t[k] >= Lp[k] + Rp[k] + 3) begin
                if (out_rdy) job[k] = 1'b0;
            end
            else t[k]++;
        end
    end

    function automatic logic [9:0] expv(input int k);
        logic [9:0] e;
        int L, R, n;
        L = Lp[k]; R = Rp[k]; n = t[k];
        e = '0;
        e[9] = !job[k] && !reset;
        e[8] = job[k];
        if (job[k]) begin
            e[7] = (n == 1);
            e[6] = (n == 1);
            e[5] = (n >= L + 2) && (n <= L + R + 1);
            e[4] = e[5];
            e[3] = (n == L + R + 2);
            e[2] = (n >= L + R + 3);
            if (n >= 2 && n <= L + 1) e[1:0] = 2'(n - 2);
        end
        return e;
    endfunction

    // ---------------- per-cycle compare and log ----------------
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int  e0[2] = '{-1000, -1000};
    bit  pbusy[2];
    logic [1:0] lw [2][128];
    logic lb[2][128], lp[2][128], ld[2][128], lk[2][128], ls[2][128], lv[2][128];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int n;
                check($sformatf("u%0d outputs", k),
                      {start_rdy[k], busy[k], dp_reset[k], lfsrset[k], dctr[k],
                       kctr[k], save[k], out_valid[k], word_idx[k]}, expv(k));
                if (busy[k] === 1'b1 && !pbusy[k]) begin
                    e0[k] = cyc - 1;
                    for (int j = 0; j < 128; j++) begin
                        lw[k][j] = '0; lb[k][j] = 0; lp[k][j] = 0; ld[k][j] = 0;
                        lk[k][j] = 0; ls[k][j] = 0; lv[k][j] = 0;
                    end
                end
                pbusy[k] = (busy[k] === 1'b1);
                n = cyc - e0[k];
                if (n >= 0 && n < 128) begin
                    lw[k][n] = word_idx[k]; lb[k][n] = busy[k]; lp[k][n] = dp_reset[k];
                    ld[k][n] = dctr[k]; lk[k][n] = kctr[k]; ls[k][n] = save[k];
                    lv[k][n] = out_valid[k];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic int cnt(input int k, input int which);
        int c = 0;
        for (int j = 0; j < 128; j++)
            case (which)
                0: c += int'(ld[k][j]);
                1: c += int'(lk[k][j]);
                2: c += int'(ls[k][j]);
                3: c += int'(lv[k][j]);
                default: c += int'(lp[k][j]);
            endcase
        return c;
    endfunction

    function automatic int first(input int k, input int which);
        for (int j = 0; j < 128; j++)
            if ((which == 0 && ld[k][j]) || (which == 2 && ls[k][j]) ||
                (which == 3 && lv[k][j]) || (which == 4 && lp[k][j])) return j;
        return -1;
    endfunction

    // Full uninterrupted job with out_rdy high: hand-derived timeline.
    task automatic check_job(input int k, input int L, input int R,
                             input int save_at, input int valid_at);
        string p;
        p = $sformatf("u%0d ", k);
        check({p, "dp_reset count"}, cnt(k, 4), 1);
        check({p, "dp_reset at"}, first(k, 4), 1);
        for (int n = 2; n <= L + 1; n++)
            check($sformatf("%sword_idx c%0d", p, n), lw[k][n], n - 2);
        check({p, "word_idx after load"}, lw[k][L + 2], 0);
        check({p, "dctr count"}, cnt(k, 0), R);
        check({p, "kctr count"}, cnt(k, 1), R);
        check({p, "first round"}, first(k, 0), L + 2);
        check({p, "save count"}, cnt(k, 2), 1);
        check({p, "save at"}, first(k, 2), save_at);
        check({p, "valid count"}, cnt(k, 3), 1);
        check({p, "valid latency"}, first(k, 3), valid_at);
        check({p, "idle after valid"}, lb[k][valid_at + 1], 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; abort = 1'b0; out_rdy = 1'b1;

        // 1: reset with start held, then release and accept
        tick(3);
        check("rst start_rdy", start_rdy, 2'b00);
        check("rst busy", busy, 2'b00);
        check("rst strobes", {dp_reset, lfsrset, dctr, kctr, save, out_valid}, 12'h000);
        reset = 1'b0;
        #1;
        check("release start_rdy", start_rdy, 2'b11);
        tick(1);
        start = 1'b0;
        check("accept busy", busy, 2'b11);
        check("busy start_rdy", start_rdy, 2'b00);

        // 2 and 6: full jobs, out_rdy high
        tick(60);
        check_job(0, 4, 32, 38, 39);
        check_job(1, 3, 44, 49, 50);

        // 3: backpressure with ignored starts
        out_rdy = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        start = 1'b1;
        tick(31);
        start = 1'b0;
        tick(7);
        out_rdy = 1'b1;
        tick(20);
        check("u0 bp valid count", cnt(0, 3), 10);
        check("u0 bp valid first", first(0, 3), 39);
        check("u0 bp valid last", lv[0][48], 1);
        check("u0 bp valid dropped", lv[0][49], 0);
        check("u0 bp save count", cnt(0, 2), 1);
        check("u1 bp save count", cnt(1, 2), 1);
        check("u1 bp valid count", cnt(1, 3), 1);
        check("bp idle end", busy, 2'b00);

        // 4: abort during round 17 of the default build
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(22);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(40);
        check("u0 abort rounds", cnt(0, 0), 18);
        check("u0 abort last round", ld[0][23], 1);
        check("u0 abort idle", lb[0][24], 0);
        check("u0 abort dctr low", ld[0][24], 0);
        check("u1 abort rounds", cnt(1, 0), 19);
        check("u0 abort save", cnt(0, 2), 0);
        check("u0 abort valid", cnt(0, 3), 0);
        check("u1 abort save", cnt(1, 2), 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(60);
        check_job(0, 4, 32, 38, 39);
        check_job(1, 3, 44, 49, 50);

        // 5: reset while word_idx = 2
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        check("u0 midload idx", lw[0][4], 2);
        check("u0 post-reset busy", lb[0][5], 0);
        check("u0 post-reset idx", lw[0][5], 0);
        check("u1 midload idx", lw[1][4], 2);
        check("u1 post-reset busy", lb[1][5], 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(60);
        check_job(0, 4, 32, 38, 39);
        check_job(1, 3, 44, 49, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
